comparator_nb_serial: RTL and testbench
=======================================

// Module: comparator_nb_serial
// PURPOSE
//  Parametrised sequential magnitude comparator for WIDTH-bit operands, signed or unsigned.
//  - Compares MSB-first, DIGIT bits per clock, so wide compares cost little area.
//  - Uses a start/busy/done handshake; results are registered and held until the next compare completes.
//  - Successor to the combinational 4-bit comparator, for datapaths where width exceeds single-cycle timing.
// PARAMETERS
//  WIDTH       8   operand width in bits; must be >= 1
//  DIGIT       2   bits examined per cycle; must be >= 1, and WIDTH % DIGIT == 0 (else elaboration error)
//  EARLY_EXIT  0   1 = finish as soon as a chunk differs; 0 = fixed latency
// PORTS
//  clk          in   1      sole clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  start        in   1      request a compare; sampled only when busy==0
//  signed_mode  in   1      1 = two's-complement compare; sampled with start
//  A            in   WIDTH  operand A; sampled with start
//  B            in   WIDTH  operand B; sampled with start
//  busy         out  1      high while a compare is in progress
//  done         out  1      one-cycle pulse; results valid from this cycle on
//  A_great_B    out  1      registered result, A > B
//  A_equal_B    out  1      registered result, A == B
//  A_less_B     out  1      registered result, A < B
// BEHAVIOUR
//  Definitions: NCHUNK = WIDTH/DIGIT. FSM states are IDLE, RUN and DONE.
//  Reset (async, any time, including mid-RUN):
//  - state goes to IDLE; busy, done, A_great_B, A_equal_B and A_less_B all go to 0.
//  - shift registers clear; a compare in flight is abandoned and no done is produced.
//  Accept, at edge E0 with start==1 and state IDLE or DONE:
//  - capture A, B and signed_mode into internal registers; state goes to RUN; busy=1 from E0.
//  - start while busy==1 is ignored; it is not queued.
//  Signed handling: when signed_mode==1, invert bit WIDTH-1 of both captured operands; then compare unsigned.
//  RUN: each edge examines the next DIGIT-bit chunk, MSB chunk first.
//  - Flags gt_seen and lt_seen are set on the first unequal chunk only; later chunks cannot change them.
//  - EARLY_EXIT=0: the last chunk is examined at edge E0+NCHUNK.
//  - EARLY_EXIT=1: RUN ends at the first edge where gt_seen or lt_seen sets; equal operands still take NCHUNK edges.
//  Completion, at the edge that ends RUN:
//  - state goes to DONE; busy=0; done=1 for exactly one cycle.
//  - A_great_B, A_equal_B and A_less_B load and are one-hot from then on.
//  - Latency with EARLY_EXIT=0: done high in the cycle after edge E0+NCHUNK.
//  DONE: lasts one cycle, then IDLE, unless start is accepted at that edge (back-to-back; done drops, busy rises).
//  Result holding: results hold through later RUN cycles and change only at the next completion.
//  - Before the first completion after reset, all three results read 0.
//  Input changes on A, B or signed_mode after E0 have no effect on the compare in progress.
//  DIGIT==WIDTH is legal: single-chunk compare, latency 1.
// TESTING
//  Directed cases below use WIDTH=8, DIGIT=2 unless stated.
//  T1 unsigned, A=0xA5, B=0xA4 -> done 4 edges after E0; A_great_B=1, others 0.
//  T2 A=0x80, B=0x7F, signed_mode=1 -> A_less_B=1; same operands with signed_mode=0 -> A_great_B=1.
//  T3 EARLY_EXIT=1, A=0xC0, B=0x40 -> done after 1 RUN edge, A_great_B=1.
//     Same build, A=B=0x3C -> done after 4 edges, A_equal_B=1.
//  T4 start pulsed during RUN -> ignored, no extra done.
//     start held through the DONE cycle -> second compare accepted; busy goes 1 the next cycle.
//  T5 rst asserted between the 2nd and 3rd RUN edges -> outputs all 0 immediately; no done; IDLE afterwards.
//  T6 WIDTH=4, DIGIT=1, both modes, all 256 A/B pairs -> results match a behavioural model; exactly one result high.

Source files
------------

// File: rtl/comparator_nb_serial.sv
`default_nettype none
// ============================================================================
// Module      : comparator_nb_serial
// Description : Serial MSB-first magnitude comparator. It examines DIGIT bits
//               per clock and uses a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module comparator_nb_serial #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_great_B,
    output logic             A_equal_B,
    output logic             A_less_B
);

    localparam int c_NCHUNK = WIDTH / DIGIT;
    localparam int c_CNT_W  = (c_NCHUNK > 1) ? $clog2(c_NCHUNK) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CHUNK = c_CNT_W'(c_NCHUNK - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("comparator_nb_serial: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_gt_seen;
    logic               r_lt_seen;
    logic               r_great;
    logic               r_equal;
    logic               r_less;

    logic [WIDTH-1:0]   w_flip;
    logic [DIGIT-1:0]   w_chunk_a;
    logic [DIGIT-1:0]   w_chunk_b;
    logic               w_unseen;
    logic               w_gt_next;
    logic               w_lt_next;
    logic               w_last;
    logic               w_accept;
    logic               w_in_run;

    // Flipping the sign bit of both operands maps two's-complement order onto unsigned order.
    always_comb begin
        w_flip            = '0;
        w_flip[WIDTH-1]   = signed_mode;
    end

    assign w_in_run  = (r_state == c_S_RUN);
    assign w_accept  = start && !w_in_run;
    assign w_chunk_a = r_a_sh[WIDTH-1 -: DIGIT];
    assign w_chunk_b = r_b_sh[WIDTH-1 -: DIGIT];
    assign w_unseen  = !r_gt_seen && !r_lt_seen;
    assign w_gt_next = r_gt_seen || (w_unseen && (w_chunk_a > w_chunk_b));
    assign w_lt_next = r_lt_seen || (w_unseen && (w_chunk_a < w_chunk_b));
    assign w_last    = (r_cnt == c_LAST_CHUNK) ||
                       ((EARLY_EXIT != 0) && (w_gt_next || w_lt_next));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: if (start) w_next_state = c_S_RUN;
            c_S_RUN:  if (w_last) w_next_state = c_S_DONE;
            c_S_DONE: w_next_state = start ? c_S_RUN : c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_S_RUN);
        done = (r_state == c_S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_cnt     <= '0;
            r_gt_seen <= 1'b0;
            r_lt_seen <= 1'b0;
            r_great   <= 1'b0;
            r_equal   <= 1'b0;
            r_less    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh    <= A ^ w_flip;
            r_b_sh    <= B ^ w_flip;
            r_cnt     <= '0;
            r_gt_seen <= 1'b0;
            r_lt_seen <= 1'b0;
        end else if (w_in_run) begin
            r_a_sh    <= r_a_sh << DIGIT;
            r_b_sh    <= r_b_sh << DIGIT;
            r_cnt     <= r_cnt + 1'b1;
            r_gt_seen <= w_gt_next;
            r_lt_seen <= w_lt_next;
            // Results only move at completion so they hold through later compares.
            if (w_last) begin
                r_great <= w_gt_next;
                r_less  <= w_lt_next;
                r_equal <= !w_gt_next && !w_lt_next;
            end
        end
    end

    assign A_great_B = r_great;
    assign A_equal_B = r_equal;
    assign A_less_B  = r_less;

endmodule
`default_nettype wire

// File: tb/tb_comparator_nb_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_nb_serial
// Description : Self-checking bench for three comparator builds: (8,2,fixed),
//               (8,2,early exit) and (4,1,fixed).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_nb_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] sm = '0;
    logic [7:0] a [3];
    logic [7:0] b [3];
    wire  [2:0] busy, done, gt, eq, lt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    comparator_nb_serial #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .signed_mode(sm[0]),
        .A(a[0]), .B(b[0]), .busy(busy[0]), .done(done[0]),
        .A_great_B(gt[0]), .A_equal_B(eq[0]), .A_less_B(lt[0]));

    comparator_nb_serial #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .signed_mode(sm[1]),
        .A(a[1]), .B(b[1]), .busy(busy[1]), .done(done[1]),
        .A_great_B(gt[1]), .A_equal_B(eq[1]), .A_less_B(lt[1]));

    comparator_nb_serial #(.WIDTH(4), .DIGIT(1), .EARLY_EXIT(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .signed_mode(sm[2]),
        .A(a[2][3:0]), .B(b[2][3:0]), .busy(busy[2]), .done(done[2]),
        .A_great_B(gt[2]), .A_equal_B(eq[2]), .A_less_B(lt[2]));

    function automatic int pw(input int i);
        return (i == 2) ? 4 : 8;
    endfunction
    function automatic int pd(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic int pe(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // Expected {gt,eq,lt} from integer comparison of the operand values.
    function automatic logic [2:0] ref_res(input int w, input logic [7:0] av, input logic [7:0] bv,
                                           input logic s);
        int x = int'(av) & ((1 << w) - 1);
        int y = int'(bv) & ((1 << w) - 1);
        if (s) begin
            if (x >= (1 << (w - 1))) x = x - (1 << w);
            if (y >= (1 << (w - 1))) y = y - (1 << w);
        end
        if (x > y) return 3'b100;
        if (x == y) return 3'b010;
        return 3'b001;
    endfunction

    // Expected edges from accept to completion: all chunks, or up to the first differing one.
    function automatic int ref_lat(input int w, input int d, input int ee,
                                   input logic [7:0] av, input logic [7:0] bv);
        int nch = w / d;
        int lat = nch;
        int m   = (1 << d) - 1;
        int ux  = int'(av) & ((1 << w) - 1);
        int uy  = int'(bv) & ((1 << w) - 1);
        if (ee != 0) begin
            for (int k = 0; k < nch; k++) begin
                if (lat == nch && (((ux >> (w - d * (k + 1))) & m) != ((uy >> (w - d * (k + 1))) & m)))
                    lat = k + 1;
            end
        end
        return lat;
    endfunction

    logic [2:0] m_busy, m_done;
    logic [2:0] m_res  [3];
    logic [2:0] m_pend [3];
    int         m_rem  [3];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= '0;
            m_done <= '0;
            for (int i = 0; i < 3; i++) begin
                m_res[i]  <= '0;
                m_pend[i] <= '0;
                m_rem[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_busy[i]) begin
                    m_done[i] <= 1'b0;
                    if (start[i]) begin
                        m_busy[i] <= 1'b1;
                        m_pend[i] <= ref_res(pw(i), a[i], b[i], sm[i]);
                        m_rem[i]  <= ref_lat(pw(i), pd(i), pe(i), a[i], b[i]);
                    end
                end else if (m_rem[i] == 1) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_res[i]  <= m_pend[i];
                end else begin
                    m_rem[i] <= m_rem[i] - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("cycle_inst%0d", i),
                  32'({busy[i], done[i], gt[i], eq[i], lt[i]}),
                  32'({m_busy[i], m_done[i], m_res[i]}));
    endtask

    task automatic wait_done(input int i, output int n);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (done[i]) break;
        end
        check($sformatf("done_seen_inst%0d", i), 32'(done[i]), 32'd1);
    endtask

    task automatic do_cmp(input int i, input logic [7:0] av, input logic [7:0] bv, input logic s,
                          input int exp_lat, input logic [2:0] exp_res, input string name);
        int n;
        a[i] = av; b[i] = bv; sm[i] = s; start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
        a[i] = 8'($urandom); b[i] = 8'($urandom); sm[i] = 1'($urandom);
        wait_done(i, n);
        if (exp_lat > 0) begin
            check({name, "_latency"}, 32'(n), 32'(exp_lat));
            check({name, "_result"}, 32'({gt[i], eq[i], lt[i]}), 32'(exp_res));
        end
        check({name, "_onehot"}, 32'($countones({gt[i], eq[i], lt[i]})), 32'd1);
        tick();
    endtask

    initial begin
        int n;
        int nd;
        for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end
        tick();
        tick();
        rst = 1'b0;
        check("reset_outputs", 32'({busy[0], done[0], gt[0], eq[0], lt[0]}), 32'd0);
        tick();

        do_cmp(0, 8'hA5, 8'hA4, 1'b0, 4, 3'b100, "t1");
        do_cmp(0, 8'h80, 8'h7F, 1'b1, 4, 3'b001, "t2_signed");
        do_cmp(0, 8'h80, 8'h7F, 1'b0, 4, 3'b100, "t2_unsigned");
        do_cmp(1, 8'hC0, 8'h40, 1'b0, 1, 3'b100, "t3_early");
        do_cmp(1, 8'h3C, 8'h3C, 1'b0, 4, 3'b010, "t3_equal");
        do_cmp(1, 8'h20, 8'h10, 1'b1, 2, 3'b100, "t3_mid");
        do_cmp(1, 8'h05, 8'h06, 1'b0, 4, 3'b001, "t3_last");
        do_cmp(2, 8'h08, 8'h07, 1'b1, 4, 3'b001, "w4_signed");

        // Start pulsed mid-RUN must not restart or queue a compare.
        a[0] = 8'h10; b[0] = 8'h20; sm[0] = 1'b0; start[0] = 1'b1;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            nd += int'(done[0]);
            if (k == 0) start[0] = 1'b0;
            if (k == 1) begin start[0] = 1'b1; a[0] = 8'hFF; b[0] = 8'h00; end
            if (k == 2) start[0] = 1'b0;
        end
        check("t4_single_done", 32'(nd), 32'd1);
        check("t4_result", 32'({gt[0], eq[0], lt[0]}), 32'b001);

        // Start held through DONE launches a back-to-back compare.
        a[0] = 8'h3C; b[0] = 8'h3C; sm[0] = 1'b0; start[0] = 1'b1;
        tick();
        wait_done(0, n);
        check("t4_first_result", 32'({gt[0], eq[0], lt[0]}), 32'b010);
        a[0] = 8'h01; b[0] = 8'h02;
        tick();
        check("t4_b2b_busy_done", 32'({busy[0], done[0]}), 32'b10);
        start[0] = 1'b0;
        wait_done(0, n);
        check("t4_b2b_latency", 32'(n), 32'd4);
        check("t4_b2b_result", 32'({gt[0], eq[0], lt[0]}), 32'b001);
        tick();

        // Asynchronous reset between the 2nd and 3rd RUN edges.
        a[0] = 8'h55; b[0] = 8'hAA; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        #1 rst = 1'b1;
        #1 check("t5_immediate_zero", 32'({busy[0], done[0], gt[0], eq[0], lt[0]}), 32'd0);
        tick();
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            nd += int'(done[0]) + int'(busy[0]);
        end
        check("t5_no_done_after_reset", 32'(nd), 32'd0);
        do_cmp(0, 8'h12, 8'h34, 1'b0, 4, 3'b001, "t5_restart");

        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    do_cmp(2, 8'(x), 8'(y), 1'(s), -1, 3'b000, "t6");

        // Random traffic on all builds, with equal and near-equal operands favoured.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 3; i++) begin
                start[i] = ($urandom_range(0, 2) == 0);
                sm[i]    = 1'($urandom);
                a[i]     = 8'($urandom);
                case ($urandom_range(0, 3))
                    0:       b[i] = a[i];
                    1:       b[i] = a[i] ^ (8'd1 << $urandom_range(0, 7));
                    default: b[i] = 8'($urandom);
                endcase
            end
            tick();
        end
        start = '0;
        for (int k = 0; k < 12; k++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
